// File: rtl/prime_rows_pkg.sv
// Shared constants, FSM encoding and text helpers for the prime_rows LCD sieve.
// Row strings pack char 0 into the most significant byte.
package prime_rows_pkg;

  localparam int N_MAX = 1023;
  localparam logic [10:0] LIMIT_11 = 11'(N_MAX);
  localparam logic [9:0]  LAST_IDX = 10'(N_MAX);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_OUTER   = 3'd1,
    ST_MARK    = 3'd2,
    ST_SEARCH  = 3'd3,
    ST_CONVERT = 3'd4,
    ST_SHOW    = 3'd5
  } state_t;

  localparam logic [7:0]   ASCII_SPACE   = 8'h20;
  localparam logic [7:0]   ASCII_ZERO    = 8'h30;
  localparam logic [127:0] ROW_COMPUTING = "Computing...    ";
  localparam logic [127:0] ROW_BLANK     = {16{ASCII_SPACE}};
  localparam logic [55:0]  TXT_PRIME     = "Prime #";
  localparam logic [47:0]  TXT_IS        = " is   ";
  localparam logic [55:0]  TXT_VALUE     = "Value: ";
  localparam logic [39:0]  TXT_PAD5      = {5{ASCII_SPACE}};

  function automatic logic [7:0] bcd_char(input logic [3:0] d);
    return ASCII_ZERO + {4'd0, d};
  endfunction

  // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [25:0] dabble_adjust(input logic [25:0] s);
    logic [25:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (r[10+4*i +: 4] >= 4'd5) begin
        r[10+4*i +: 4] = r[10+4*i +: 4] + 4'd3;
      end else begin
        r[10+4*i +: 4] = r[10+4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] make_row_a(input logic [15:0] idx_bcd);
    return {TXT_PRIME, bcd_char(idx_bcd[11:8]), bcd_char(idx_bcd[7:4]),
            bcd_char(idx_bcd[3:0]), TXT_IS};
  endfunction

  function automatic logic [127:0] make_row_b(input logic [15:0] val_bcd);
    return {TXT_VALUE, bcd_char(val_bcd[15:12]), bcd_char(val_bcd[11:8]),
            bcd_char(val_bcd[7:4]), bcd_char(val_bcd[3:0]), TXT_PAD5};
  endfunction

endpackage

// File: rtl/prime_rows_bin2bcd.sv
// Sequential double-dabble converter: 10-bit binary to 4 BCD digits.
// A start pulse loads the value; done pulses for one cycle when bcd is valid.
module bin2bcd
  import prime_rows_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [25:0] shift_r;
  logic [25:0] adj_s;
  logic [25:0] shift_next_s;
  logic [3:0]  cnt_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] bcd_r;

  // Correction plus one-bit shift for the current iteration
  always_comb begin
    adj_s        = dabble_adjust(shift_r);
    shift_next_s = adj_s << 1;
  end

  // Shift register, iteration counter and registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= 26'd0;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_r   <= 16'd0;
    end else begin
      done_r <= 1'b0;
      if (start && !busy_r) begin
        shift_r <= {16'd0, bin};
        cnt_r   <= 4'd10;
        busy_r  <= 1'b1;
      end else if (busy_r) begin
        shift_r <= shift_next_s;
        cnt_r   <= cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          bcd_r  <= shift_next_s[25:10];
        end
      end
    end
  end

  assign bcd  = bcd_r;
  assign done = done_r;

endmodule

// File: rtl/prime_rows.sv
// Sieve of Eratosthenes over 0..1023 that steps through the primes on demand
// and renders "Prime #iii is" / "Value: vvvv" for a 2x16 LCD.
module prime_rows
  import prime_rows_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [127:0] row_A,
  output logic [127:0] row_B,
  output logic         ready
);

  state_t       state_r;
  state_t       state_next_s;

  logic         flag_r [0:1023];
  logic         flag_we_s;
  logic [9:0]   flag_addr_s;
  logic         flag_data_s;
  logic         flag_p_s;
  logic         flag_scan_s;

  logic [5:0]   p_r;
  logic [9:0]   m_r;
  logic [9:0]   cur_r;
  logic [7:0]   idx_r;
  logic [9:0]   scan_r;
  logic [1:0]   phase_r;
  logic [15:0]  val_bcd_r;
  logic [127:0] row_a_r;
  logic [127:0] row_b_r;
  logic         ready_r;

  logic [10:0]  prod_s;
  logic [10:0]  sum_s;

  logic         cv_start_s;
  logic [9:0]   cv_bin_s;
  logic [15:0]  cv_bcd_s;
  logic         cv_done_s;

  bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (cv_start_s),
    .bin   (cv_bin_s),
    .bcd   (cv_bcd_s),
    .done  (cv_done_s)
  );

  // Sieve arithmetic in 11 bits so the 1023 limit compare cannot wrap
  always_comb begin
    prod_s      = {5'd0, p_r} * {5'd0, p_r};
    sum_s       = {1'b0, m_r} + {5'd0, p_r};
    flag_p_s    = flag_r[{4'd0, p_r}];
    flag_scan_s = flag_r[scan_r];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, flag write port and converter request
  always_comb begin
    state_next_s = state_r;
    flag_we_s    = 1'b0;
    flag_addr_s  = m_r;
    flag_data_s  = 1'b0;
    cv_start_s   = 1'b0;
    cv_bin_s     = cur_r;
    case (state_r)
      ST_INIT: begin
        flag_we_s   = 1'b1;
        flag_data_s = (m_r >= 10'd2);
        if (m_r == LAST_IDX) begin
          state_next_s = ST_OUTER;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_OUTER: begin
        if (prod_s > LIMIT_11) begin
          state_next_s = ST_SEARCH;
        end else if (flag_p_s) begin
          state_next_s = ST_MARK;
        end else begin
          state_next_s = ST_OUTER;
        end
      end
      ST_MARK: begin
        flag_we_s = 1'b1;
        if (sum_s > LIMIT_11) begin
          state_next_s = ST_OUTER;
        end else begin
          state_next_s = ST_MARK;
        end
      end
      ST_SEARCH: begin
        if (flag_scan_s) begin
          state_next_s = ST_CONVERT;
        end else begin
          state_next_s = ST_SEARCH;
        end
      end
      ST_CONVERT: begin
        case (phase_r)
          2'd0: begin
            cv_start_s = 1'b1;
            cv_bin_s   = cur_r;
          end
          2'd2: begin
            cv_start_s = 1'b1;
            cv_bin_s   = {2'd0, idx_r};
          end
          2'd3: begin
            if (cv_done_s) begin
              state_next_s = ST_SHOW;
            end else begin
              state_next_s = ST_CONVERT;
            end
          end
          default: begin
            cv_start_s = 1'b0;
          end
        endcase
      end
      ST_SHOW: begin
        if (step) begin
          state_next_s = ST_SEARCH;
        end else begin
          state_next_s = ST_SHOW;
        end
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase
  end

  // Flag array: rewritten completely by INIT after every reset, so no reset here
  always_ff @(posedge clk) begin
    if (flag_we_s) begin
      flag_r[flag_addr_s] <= flag_data_s;
    end
  end

  // Datapath: sieve pointers, search position, conversion results and display rows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_r       <= 6'd2;
      m_r       <= 10'd0;
      cur_r     <= 10'd1;
      idx_r     <= 8'd0;
      scan_r    <= 10'd2;
      phase_r   <= 2'd0;
      val_bcd_r <= 16'd0;
      row_a_r   <= ROW_COMPUTING;
      row_b_r   <= ROW_BLANK;
      ready_r   <= 1'b0;
    end else begin
      ready_r <= (state_next_s == ST_SHOW);
      case (state_r)
        ST_INIT: begin
          m_r <= m_r + 10'd1;
          p_r <= 6'd2;
        end
        ST_OUTER: begin
          if (prod_s > LIMIT_11) begin
            scan_r <= cur_r + 10'd1;
          end else if (flag_p_s) begin
            m_r <= prod_s[9:0];
          end else begin
            p_r <= p_r + 6'd1;
          end
        end
        ST_MARK: begin
          if (sum_s > LIMIT_11) begin
            p_r <= p_r + 6'd1;
          end else begin
            m_r <= sum_s[9:0];
          end
        end
        ST_SEARCH: begin
          if (flag_scan_s) begin
            cur_r   <= scan_r;
            idx_r   <= idx_r + 8'd1;
            phase_r <= 2'd0;
          end else if (scan_r == LAST_IDX) begin
            // Past the last prime: restart the cycle at 2 as entry #1
            scan_r <= 10'd2;
            idx_r  <= 8'd0;
          end else begin
            scan_r <= scan_r + 10'd1;
          end
        end
        ST_CONVERT: begin
          case (phase_r)
            2'd0: phase_r <= 2'd1;
            2'd1: begin
              if (cv_done_s) begin
                val_bcd_r <= cv_bcd_s;
                phase_r   <= 2'd2;
              end
            end
            2'd2: phase_r <= 2'd3;
            2'd3: begin
              if (cv_done_s) begin
                row_a_r <= make_row_a(cv_bcd_s);
                row_b_r <= make_row_b(val_bcd_r);
                phase_r <= 2'd0;
              end
            end
            default: phase_r <= 2'd0;
          endcase
        end
        ST_SHOW: begin
          if (step) begin
            scan_r <= cur_r + 10'd1;
          end
        end
        default: begin
          phase_r <= 2'd0;
        end
      endcase
    end
  end

  assign row_A = row_a_r;
  assign row_B = row_b_r;
  assign ready = ready_r;

endmodule
